syscall_ctrl: RTL and testbench
===============================

# syscall_ctrl

Hardware syscall sequencer for the single-cycle MIPS core: replaces simulation-only syscall handling with synthesizable logic. On a decoded `syscall` it stalls the core and services the request in `$v0` using `$a0`: print integer, print string (walks data memory through a shared memory port), sbrk heap allocation (writes the old heap pointer back to `$v0`), or exit. Sits beside the controller; drives the core stall, a `$v0` write port, a memory read request to the data/heap memory arbiter, and character/integer output streams.

## Interface
- `HEAP_BASE`, 32'h10000000, initial heap pointer and lowest heap address
- `HEAP_LIMIT`, 32'h10001000, exclusive upper bound for the heap pointer
- `MAX_STR`, 1024, maximum characters emitted per print-string call
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `syscall`  in  1  controller SysCall decode, high while the syscall instruction is current
- `v0_in`  in  32  `$v0` read value (syscall code)
- `a0_in`  in  32  `$a0` read value (argument)
- `stall`  out  1  freezes PC and register/memory writes of the core
- `rf_we`  out  1  write enable for `$v0` (register 2)
- `rf_wdata`  out  32  value written to `$v0`
- `mem_req`  out  1  read request to data/heap memory arbiter
- `mem_addr`  out  32  word-aligned byte address
- `mem_gnt`  in  1  grant; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  32  read word, big-endian byte order
- `char_valid` / `char_ready`  out / in  1  character stream handshake
- `char_data`  out  8  ASCII character
- `int_valid` / `int_ready`  out / in  1  integer stream handshake
- `int_data`  out  32  signed integer to print
- `heap_ptr`  out  32  current heap pointer
- `halted`  out  1  exit syscall executed
- `err`  out  1  one-cycle pulse: unsupported code, sbrk overflow, or string over `MAX_STR`

## Operation
- States: IDLE, INT_OUT, STR_FETCH, STR_EMIT, SBRK_WB, DONE, HALT.
- IDLE: on `syscall`, latch `v0_in`/`a0_in`. Code 1 -> INT_OUT; 4 -> STR_FETCH; 9 -> SBRK_WB; 10 -> HALT; other -> pulse `err`, go to DONE.
- INT_OUT: `int_valid`=1, `int_data`=latched a0; when `int_ready` -> DONE.
- STR_FETCH: `mem_req`=1, `mem_addr`={addr[31:2],2'b00}; when `mem_gnt`, latch word and go to STR_EMIT.
- STR_EMIT: byte = word[31-8*addr[1:0] -: 8]. A zero byte ends the string; it is not emitted, go to DONE. Otherwise drive `char_valid`. On `char_ready`: addr+1, count+1. If count reaches `MAX_STR`, pulse `err` and go to DONE. Else if new addr[1:0]==0, go to STR_FETCH; else stay.
- SBRK_WB: req = (a0+3)&~3. If heap_ptr+req ≤ `HEAP_LIMIT` (33-bit compare): `rf_wdata`=heap_ptr, heap_ptr += req. Otherwise `rf_wdata`=32'hFFFFFFFF, heap_ptr unchanged, pulse `err`. `rf_we`=1 for exactly this cycle. Then go to DONE.
- DONE: `stall`=0 so the syscall retires at this edge; `syscall` is ignored. Next state is IDLE.
- HALT: `halted`=1 and `stall`=1 until reset.
- `stall` = (IDLE & `syscall`) | (state ∉ {IDLE, DONE}); this term is combinational in IDLE.

## Timing
- Reset values: state IDLE, heap_ptr=`HEAP_BASE`. All other outputs are 0: `stall`, `rf_we`, `mem_req`, `char_valid`, `int_valid`, `halted`, `err`. `rf_wdata`, `mem_addr`, `char_data` and `int_data` also reset to 0.
- Reset asserted mid-operation abandons the call: a partial string stops, no `$v0` write occurs, and the heap pointer returns to base.
- Minimum stall cycles before the retire cycle:
  - print int: 2, with `int_ready` tied high
  - sbrk: 2
  - unsupported code: 1
  - print string of n chars, with grant and ready tied high: 2 + n + ceil((n+1+addr[1:0])/4)
- Outputs are stable while valid/req is high and not yet accepted.
- Zero-length sbrk returns the current pointer unchanged with no error.

## Structure
- Package `syscall_pkg`: state enum; code constants `SYS_PRINT_INT`=1, `SYS_PRINT_STR`=4, `SYS_SBRK`=9, `SYS_EXIT`=10; byte-lane select function.
- Single module; no sub-module needed.

## Test plan
- Print int: v0=1, a0=-5, `int_ready` high -> `int_data`=32'hFFFFFFFB for one beat; `stall` high for 2 cycles, then DONE.
- Print string: "Hi" at 0x0000_0002, memory word 0x0000_4869, next word 0x0000_0000 -> chars 0x48, 0x69; two fetches; no char emitted for the NUL.
- Backpressure: `char_ready` low for 5 cycles -> `char_data` held stable; `stall` stays high.
- sbrk: a0=5 twice -> `$v0` written 0x10000000 then 0x10000008; `heap_ptr`=0x10000010.
- sbrk overflow: a0=0x2000 -> `$v0`=0xFFFFFFFF, `err` pulses, `heap_ptr` unchanged.
- Exit then reset: v0=10 -> `halted`=1, `stall` held high. Reset low mid print-string -> all outputs 0, back to IDLE.

Source files
------------

// File: rtl/syscall_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : syscall_pkg
//  Purpose  : Shared types and constants for the hardware syscall sequencer.
//             Holds the sequencer state encoding, the supported MIPS syscall
//             codes and the big-endian byte-lane extraction helper.
//  Revision : 1.0  initial release
// ============================================================================
package syscall_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INT_OUT   = 3'd1,
        ST_STR_FETCH = 3'd2,
        ST_STR_EMIT  = 3'd3,
        ST_SBRK_WB   = 3'd4,
        ST_DONE      = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    // Syscall codes carried in $v0
    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR = 32'd4;
    localparam logic [31:0] SYS_SBRK      = 32'd9;
    localparam logic [31:0] SYS_EXIT      = 32'd10;

    // Memory words are big-endian: byte offset 0 is the most significant lane.
    function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                             input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage : syscall_pkg
`default_nettype wire

// File: rtl/syscall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : syscall_ctrl
//  Purpose  : Synthesizable syscall sequencer for the single-cycle MIPS core.
//             On a decoded syscall it stalls the core and services $v0:
//             print int (1), print string (4), sbrk (9) and exit (10).
//  Ports    :
//    clk, reset          clock; asynchronous active-low reset
//    syscall             controller SysCall decode
//    v0_in, a0_in        $v0 (code) and $a0 (argument) read values
//    stall               freezes PC and register/memory writes of the core
//    rf_we, rf_wdata     $v0 write-back port
//    mem_req, mem_addr   word read request to the data/heap memory arbiter
//    mem_gnt, mem_rdata  grant with same-cycle read data (big-endian)
//    char_*              ASCII character stream (valid/ready)
//    int_*               signed integer stream (valid/ready)
//    heap_ptr            current heap pointer
//    halted              exit syscall executed
//    err                 one-cycle pulse: bad code, sbrk overflow, long string
//  Revision : 1.0  initial release
// ============================================================================
module syscall_ctrl
    import syscall_pkg::*;
#(
    parameter logic [31:0] HEAP_BASE  = 32'h1000_0000,
    parameter logic [31:0] HEAP_LIMIT = 32'h1000_1000,
    parameter int unsigned MAX_STR    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall,
    input  logic [31:0] v0_in,
    input  logic [31:0] a0_in,
    output logic        stall,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [31:0] mem_rdata,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_data,
    output logic        int_valid,
    input  logic        int_ready,
    output logic [31:0] int_data,
    output logic [31:0] heap_ptr,
    output logic        halted,
    output logic        err
);

    localparam int unsigned          c_cnt_w   = $clog2(MAX_STR + 1);
    localparam logic [c_cnt_w-1:0]   c_max_str = c_cnt_w'(MAX_STR);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_next_state;
    logic [31:0]          r_arg;       // $a0; doubles as the string byte pointer
    logic [31:0]          r_word;      // last fetched string word
    logic [c_cnt_w-1:0]   r_count;     // characters emitted in this call
    logic [31:0]          r_heap_ptr;

    // Datapath control from the FSM
    logic                 w_latch;     // capture $a0 at dispatch
    logic                 w_advance;   // character accepted: step pointer/count
    logic                 w_word_we;   // capture granted read word
    logic                 w_heap_we;   // commit sbrk allocation

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                 w_call;
    logic [7:0]           w_byte;
    logic [c_cnt_w-1:0]   w_count_inc;
    logic [32:0]          w_req;
    logic [33:0]          w_heap_sum;
    logic                 w_sbrk_ok;

    // Hold the IDLE-state stall/err terms quiet while reset is asserted so
    // every output reads zero during reset even if the core keeps decoding
    // a syscall.
    assign w_call      = syscall & reset;
    assign w_byte      = byte_lane(r_word, r_arg[1:0]);
    assign w_count_inc = r_count + 1'b1;

    // Request rounded up to a word multiple; the carry out of a0+3 is kept
    // so a huge a0 cannot wrap to a small allocation.
    assign w_req       = ({1'b0, r_arg} + 33'd3) & ~33'd3;
    assign w_heap_sum  = {2'b00, r_heap_ptr} + {1'b0, w_req};
    assign w_sbrk_ok   = (w_heap_sum <= {2'b00, HEAP_LIMIT});

    assign heap_ptr    = r_heap_ptr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        rf_we        = 1'b0;
        rf_wdata     = 32'd0;
        mem_req      = 1'b0;
        mem_addr     = 32'd0;
        char_valid   = 1'b0;
        char_data    = 8'd0;
        int_valid    = 1'b0;
        int_data     = 32'd0;
        halted       = 1'b0;
        err          = 1'b0;
        w_latch      = 1'b0;
        w_advance    = 1'b0;
        w_word_we    = 1'b0;
        w_heap_we    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_call) begin
                    // Stall must rise in the same cycle the syscall is decoded.
                    stall   = 1'b1;
                    w_latch = 1'b1;
                    case (v0_in)
                        SYS_PRINT_INT: w_next_state = ST_INT_OUT;
                        SYS_PRINT_STR: w_next_state = ST_STR_FETCH;
                        SYS_SBRK:      w_next_state = ST_SBRK_WB;
                        SYS_EXIT:      w_next_state = ST_HALT;
                        default: begin
                            err          = 1'b1;
                            w_next_state = ST_DONE;
                        end
                    endcase
                end
            end

            ST_INT_OUT: begin
                stall     = 1'b1;
                int_valid = 1'b1;
                int_data  = r_arg;
                if (int_ready) begin
                    w_next_state = ST_DONE;
                end
            end

            ST_STR_FETCH: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {r_arg[31:2], 2'b00};
                if (mem_gnt) begin
                    w_word_we    = 1'b1;
                    w_next_state = ST_STR_EMIT;
                end
            end

            ST_STR_EMIT: begin
                stall = 1'b1;
                if (w_byte == 8'd0) begin
                    // Terminating NUL is consumed, never emitted.
                    w_next_state = ST_DONE;
                end else begin
                    char_valid = 1'b1;
                    char_data  = w_byte;
                    if (char_ready) begin
                        w_advance = 1'b1;
                        if (w_count_inc == c_max_str) begin
                            err          = 1'b1;
                            w_next_state = ST_DONE;
                        end else if (r_arg[1:0] == 2'b11) begin
                            // Pointer crosses into the next word.
                            w_next_state = ST_STR_FETCH;
                        end
                    end
                end
            end

            ST_SBRK_WB: begin
                stall        = 1'b1;
                rf_we        = 1'b1;
                w_next_state = ST_DONE;
                if (w_sbrk_ok) begin
                    rf_wdata  = r_heap_ptr;
                    w_heap_we = 1'b1;
                end else begin
                    rf_wdata  = 32'hFFFF_FFFF;
                    err       = 1'b1;
                end
            end

            ST_DONE: begin
                // Stall released so the syscall instruction retires at this
                // edge; the still-asserted decode is deliberately ignored.
                w_next_state = ST_IDLE;
            end

            ST_HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_arg      <= 32'd0;
            r_word     <= 32'd0;
            r_count    <= '0;
            r_heap_ptr <= HEAP_BASE;
        end else begin
            if (w_latch) begin
                r_arg   <= a0_in;
                r_count <= '0;
            end else if (w_advance) begin
                r_arg   <= r_arg + 32'd1;
                r_count <= w_count_inc;
            end
            if (w_word_we) begin
                r_word <= mem_rdata;
            end
            if (w_heap_we) begin
                r_heap_ptr <= w_heap_sum[31:0];
            end
        end
    end

endmodule : syscall_ctrl
`default_nettype wire

// File: tb/tb_syscall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_syscall_ctrl
//  Purpose  : Self-checking bench for syscall_ctrl. Directed cases plus
//             randomized syscalls compared against a behavioural model
//             (byte memory walk, integer heap arithmetic, cycle formula).
//  Revision : 1.0  initial release
// ============================================================================
module tb_syscall_ctrl;

    localparam logic [31:0] HEAP_BASE  = 32'h1000_0000;
    localparam logic [31:0] HEAP_LIMIT = 32'h1000_1000;
    localparam int          MAX_STR    = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        syscall = 1'b0;
    logic [31:0] v0_in = 32'd0;
    logic [31:0] a0_in = 32'd0;
    logic        stall, rf_we, mem_req, char_valid, int_valid, halted, err;
    logic [31:0] rf_wdata, mem_addr, int_data, heap_ptr;
    logic [7:0]  char_data;
    logic        mem_gnt = 1'b1;
    logic        char_ready = 1'b1;
    logic        int_ready = 1'b1;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    syscall_ctrl #(
        .HEAP_BASE  (HEAP_BASE),
        .HEAP_LIMIT (HEAP_LIMIT),
        .MAX_STR    (MAX_STR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .syscall    (syscall),
        .v0_in      (v0_in),
        .a0_in      (a0_in),
        .stall      (stall),
        .rf_we      (rf_we),
        .rf_wdata   (rf_wdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rdata  (mem_rdata),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_data  (char_data),
        .int_valid  (int_valid),
        .int_ready  (int_ready),
        .int_data   (int_data),
        .heap_ptr   (heap_ptr),
        .halted     (halted),
        .err        (err)
    );

    // Byte-addressed memory model; words are served big-endian.
    logic [7:0] bmem [0:255];
    logic [7:0] w_a;
    always_comb begin
        w_a       = {mem_addr[7:2], 2'b00};
        mem_rdata = mem_gnt ? {bmem[w_a], bmem[w_a + 8'd1], bmem[w_a + 8'd2], bmem[w_a + 8'd3]}
                            : 32'hA5A5_A5A5;
    end

    int     n_checks = 0;
    int     n_fail   = 0;
    int     hold_left = 0;
    longint model_heap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "/stall"},      stall,      0);
        check_eq({tag, "/rf_we"},      rf_we,      0);
        check_eq({tag, "/mem_req"},    mem_req,    0);
        check_eq({tag, "/char_valid"}, char_valid, 0);
        check_eq({tag, "/int_valid"},  int_valid,  0);
        check_eq({tag, "/halted"},     halted,     0);
        check_eq({tag, "/err"},        err,        0);
        check_eq({tag, "/rf_wdata"},   rf_wdata,   0);
        check_eq({tag, "/mem_addr"},   mem_addr,   0);
        check_eq({tag, "/char_data"},  char_data,  0);
        check_eq({tag, "/int_data"},   int_data,   0);
        check_eq({tag, "/heap_ptr"},   heap_ptr,   HEAP_BASE);
    endtask

    // mode 0: all handshakes ready; mode 1: random; mode 2: char_ready held
    // low for the first hold_left cycles a character is offered.
    task automatic drive_handshakes(input int mode);
        case (mode)
            0: begin
                char_ready = 1'b1; int_ready = 1'b1; mem_gnt = 1'b1;
            end
            1: begin
                char_ready = ($urandom_range(0, 3) != 0);
                int_ready  = ($urandom_range(0, 3) != 0);
                mem_gnt    = ($urandom_range(0, 3) != 0);
            end
            default: begin
                int_ready = 1'b1; mem_gnt = 1'b1;
                if (char_valid && hold_left > 0) begin
                    char_ready = 1'b0;
                    hold_left--;
                end else begin
                    char_ready = 1'b1;
                end
            end
        endcase
    endtask

    task automatic do_syscall(input string name, input logic [31:0] code,
                              input logic [31:0] arg, input int mode);
        logic [7:0]  exp_chars[$];
        logic [7:0]  got_chars[$];
        int          exp_ints, n_ints, exp_we, n_we, exp_err, n_err;
        int          exp_stall, stalls, exp_fetch, n_fetch, t, a, off;
        logic [31:0] exp_wdata, got_wdata, got_int;
        longint      req;
        bit          retired, p_c, p_m, p_i;
        logic [7:0]  p_cd;
        logic [31:0] p_ma, p_id;

        exp_ints = 0; n_ints = 0; exp_we = 0; n_we = 0; exp_err = 0; n_err = 0;
        exp_stall = 0; stalls = 0; exp_fetch = 0; n_fetch = 0;
        exp_wdata = 0; got_wdata = 0; got_int = 0;
        retired = 0; p_c = 0; p_m = 0; p_i = 0; p_cd = 0; p_ma = 0; p_id = 0;

        // ---- reference model ----
        if (code == 32'd1) begin
            exp_ints  = 1;
            exp_stall = 2;
        end else if (code == 32'd4) begin
            a   = int'(arg[7:0]);
            off = int'(arg[1:0]);
            t   = 0;
            forever begin
                if (bmem[a] == 8'd0) begin
                    t = exp_chars.size() + 1;
                    break;
                end
                exp_chars.push_back(bmem[a]);
                a++;
                if (exp_chars.size() == MAX_STR) begin
                    exp_err = 1;
                    t = exp_chars.size();
                    break;
                end
            end
            exp_fetch = (off + t + 3) / 4;
            exp_stall = 1 + t + exp_fetch;
        end else if (code == 32'd9) begin
            req       = ((longint'(arg) + 3) / 4) * 4;
            exp_we    = 1;
            exp_stall = 2;
            if (model_heap + req <= longint'(HEAP_LIMIT)) begin
                exp_wdata  = 32'(model_heap);
                model_heap = model_heap + req;
            end else begin
                exp_wdata = 32'hFFFF_FFFF;
                exp_err   = 1;
            end
        end else begin
            exp_err   = 1;
            exp_stall = 1;
        end
        if (mode == 2) begin
            hold_left = 5;
            exp_stall = exp_stall + 5;
        end

        // ---- drive and observe ----
        @(posedge clk); #1;
        syscall = 1'b1; v0_in = code; a0_in = arg;
        drive_handshakes(mode);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (p_c) begin
                check_eq({name, "/char_valid_hold"}, char_valid, 1);
                check_eq({name, "/char_data_hold"},  char_data,  p_cd);
            end
            if (p_m) begin
                check_eq({name, "/mem_req_hold"},  mem_req,  1);
                check_eq({name, "/mem_addr_hold"}, mem_addr, p_ma);
            end
            if (p_i) begin
                check_eq({name, "/int_valid_hold"}, int_valid, 1);
                check_eq({name, "/int_data_hold"},  int_data,  p_id);
            end
            if (char_valid && char_ready) got_chars.push_back(char_data);
            if (int_valid && int_ready) begin n_ints++; got_int = int_data; end
            if (mem_req && mem_gnt) n_fetch++;
            if (rf_we) begin n_we++; got_wdata = rf_wdata; end
            if (err) n_err++;
            p_c = char_valid && !char_ready; p_cd = char_data;
            p_m = mem_req && !mem_gnt;       p_ma = mem_addr;
            p_i = int_valid && !int_ready;   p_id = int_data;
            if (!stall) begin
                retired = 1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
            drive_handshakes(mode);
        end
        if (!retired) check_eq({name, "/timeout"}, 1, 0);
        @(posedge clk); #1;
        syscall = 1'b0; v0_in = 32'd0; a0_in = 32'd0;
        drive_handshakes(0);

        // ---- compare ----
        check_eq({name, "/nchars"}, got_chars.size(), exp_chars.size());
        for (int i = 0; i < got_chars.size() && i < exp_chars.size(); i++)
            check_eq({name, "/char"}, got_chars[i], exp_chars[i]);
        check_eq({name, "/nints"}, n_ints, exp_ints);
        if (exp_ints != 0) check_eq({name, "/int_data"}, got_int, arg);
        check_eq({name, "/rf_we_count"}, n_we, exp_we);
        if (exp_we != 0) check_eq({name, "/rf_wdata"}, got_wdata, exp_wdata);
        check_eq({name, "/err_count"}, n_err, exp_err);
        check_eq({name, "/heap_ptr"}, heap_ptr, 32'(model_heap));
        if (code == 32'd4) check_eq({name, "/fetches"}, n_fetch, exp_fetch);
        if (mode == 1) check_eq({name, "/stall_min"}, (stalls >= exp_stall), 1);
        else           check_eq({name, "/stall_cycles"}, stalls, exp_stall);
    endtask

    initial begin
        logic [31:0] code, arg;
        int          sel, mode;

        // Memory image: random non-zero text with scattered terminators,
        // "Hi" at 0x2, and a 33-character run at 0x8 for the length limit.
        for (int i = 0; i < 256; i++) bmem[i] = 8'($urandom_range(1, 255));
        for (int k = 0; k < 24; k++) bmem[$urandom_range(48, 254)] = 8'd0;
        bmem[255] = 8'd0;
        bmem[0] = 8'h00; bmem[1] = 8'h00; bmem[2] = 8'h48; bmem[3] = 8'h69;
        for (int i = 4; i < 8; i++) bmem[i] = 8'h00;
        for (int i = 8; i < 41; i++) bmem[i] = 8'(8'h41 + (i % 26));
        bmem[41] = 8'h00;
        model_heap = longint'(HEAP_BASE);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        do_syscall("print_int",  32'd1, 32'hFFFF_FFFB, 0);
        do_syscall("print_hi",   32'd4, 32'h0000_0002, 0);
        do_syscall("backpress",  32'd4, 32'h0000_0002, 2);
        do_syscall("sbrk_a",     32'd9, 32'd5, 0);
        do_syscall("sbrk_b",     32'd9, 32'd5, 0);
        check_eq("sbrk_pair_heap", heap_ptr, 32'h1000_0010);
        do_syscall("sbrk_ovf",   32'd9, 32'h0000_2000, 0);
        do_syscall("sbrk_zero",  32'd9, 32'd0, 0);
        do_syscall("str_trunc",  32'd4, 32'd8, 0);
        do_syscall("str_max",    32'd4, 32'd25, 0);
        do_syscall("str_max_m1", 32'd4, 32'd26, 0);
        do_syscall("unsup",      32'd3, 32'd0, 0);
        do_syscall("unsup_big",  32'h8000_0001, 32'd7, 0);

        for (int k = 0; k < 40; k++) begin
            sel  = $urandom_range(0, 3);
            mode = $urandom_range(0, 1);
            case (sel)
                0: begin code = 32'd1; arg = $urandom; end
                1: begin code = 32'd4; arg = $urandom_range(0, 250); end
                2: begin code = 32'd9; arg = $urandom_range(0, 32'h600); end
                default: begin
                    code = $urandom;
                    if (code == 1 || code == 4 || code == 9 || code == 10) code = code + 100;
                    arg = $urandom;
                end
            endcase
            do_syscall("rand", code, arg, mode);
        end

        // Exit: halted and stall stay high until reset.
        @(posedge clk); #1;
        syscall = 1'b1; v0_in = 32'd10; a0_in = 32'd0;
        @(negedge clk);
        check_eq("exit/dispatch_stall", stall, 1);
        repeat (4) begin
            @(negedge clk);
            check_eq("exit/halted", halted, 1);
            check_eq("exit/stall",  stall,  1);
        end
        @(posedge clk); #1;
        reset = 1'b0; syscall = 1'b0; v0_in = 32'd0;
        model_heap = longint'(HEAP_BASE);
        @(negedge clk);
        check_reset_outputs("exit_reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // Move the heap, then abandon a stalled print-string with reset.
        do_syscall("pre_rst_sbrk", 32'd9, 32'd40, 0);
        @(posedge clk); #1;
        syscall = 1'b1; v0_in = 32'd4; a0_in = 32'd8;
        char_ready = 1'b0; mem_gnt = 1'b1; int_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("mid/char_offered", char_valid, 1);
        #2;
        reset = 1'b0; syscall = 1'b0; v0_in = 32'd0; a0_in = 32'd0;
        model_heap = longint'(HEAP_BASE);
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        reset = 1'b1; char_ready = 1'b1;
        do_syscall("post_rst_int",  32'd1, 32'h1234_5678, 0);
        do_syscall("post_rst_sbrk", 32'd9, 32'd1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_syscall_ctrl
`default_nettype wire
